pipe_stage_chain: RTL and testbench

Parametrised pipeline-register chain for the core's inter-stage buses, generalising the single EX/DC-style register to DEPTH back-to-back slots of WIDTH bits.
- Each slot carries an explicit valid bit and is controlled by its own bit of the global stall bus.
- Global flush clears every slot.
- Optional per-chain performance counters.
- Sits between any two pipeline stages, e.g. EX to DC to MEM as a DEPTH=2 chain.

---
 rtl/pipe_stage_chain_pkg.sv | 25 ++
 rtl/pipe_stage_chain_slot.sv | 46 ++++
 rtl/pipe_stage_chain.sv | 82 ++++++++
 tb/tb_pipe_stage_chain.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_chain_pkg.sv
// pipe_stage_chain_pkg: stall-bus encoding, bus widths and the per-slot update decision
package pipe_stage_chain_pkg;

    localparam int   STALL_W    = 8;
    localparam logic STOP       = 1'b1;
    localparam logic NO_STOP    = 1'b0;
    localparam int   PIPE_CNT_W = 32;
    localparam int   EX_WD      = 76;
    localparam int   DC_WD      = 76;

    typedef enum logic [1:0] {
        SLOT_FLUSH,
        SLOT_BUBBLE,
        SLOT_ADVANCE,
        SLOT_HOLD
    } slot_op_e;

    // h is this slot's stall bit, d the downstream slot's; first match wins
    function automatic slot_op_e slot_op(input logic flush, input logic h, input logic d);
        return flush                      ? SLOT_FLUSH   :
               (h == STOP && d == NO_STOP) ? SLOT_BUBBLE  :
               (h == NO_STOP)              ? SLOT_ADVANCE : SLOT_HOLD;
    endfunction

endpackage

// File: rtl/pipe_stage_chain_slot.sv
// pipe_slot: one valid+payload pipeline register driven by its own and the downstream stall bit
module pipe_slot
    import pipe_stage_chain_pkg::*;
#(
    parameter int WIDTH      = 76,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_h,
    input  logic             i_d,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    slot_op_e         w_op;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    assign w_op    = slot_op(i_flush, i_h, i_d);
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            case (w_op)
                SLOT_FLUSH, SLOT_BUBBLE: begin
                    r_valid <= 1'b0;
                    if (CLEAR_DATA) r_data <= '0;
                end
                SLOT_ADVANCE: begin
                    r_valid <= i_valid;
                    r_data  <= i_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: DEPTH back-to-back pipe_slot registers with occupancy;
// bubble/hold perf counters are built only when PIPE_STAGE_PERF_EN is defined
module pipe_stage_chain
    import pipe_stage_chain_pkg::*;
#(
    parameter int WIDTH      = 76,
    parameter int DEPTH      = 1,
    parameter int STALL_LO   = 4,
    parameter bit CLEAR_DATA = 1'b1,
    localparam int OCC_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_flush,
    input  logic [STALL_W-1:0]    i_stall,
    input  logic                  i_valid,
    input  logic [WIDTH-1:0]      i_data,
    output logic                  o_valid,
    output logic [WIDTH-1:0]      o_data,
    output logic [OCC_W-1:0]      o_occupancy,
    output logic [PIPE_CNT_W-1:0] o_bubble_cnt,
    output logic [PIPE_CNT_W-1:0] o_hold_cnt
);

    logic [DEPTH:0]   w_valid;
    logic [WIDTH-1:0] w_data [DEPTH+1];
    logic             w_unused;

    assign w_valid[0] = i_valid;
    assign w_data[0]  = i_data;
    assign w_unused   = ^i_stall;

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        pipe_slot #(
            .WIDTH      (WIDTH),
            .CLEAR_DATA (CLEAR_DATA)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .i_flush (i_flush),
            .i_h     (i_stall[STALL_LO+k]),
            .i_d     (i_stall[STALL_LO+k+1]),
            .i_valid (w_valid[k]),
            .i_data  (w_data[k]),
            .o_valid (w_valid[k+1]),
            .o_data  (w_data[k+1])
        );
    end

    assign o_valid = w_valid[DEPTH];
    assign o_data  = w_data[DEPTH];

    always_comb begin
        o_occupancy = '0;
        for (int k = 1; k <= DEPTH; k++) o_occupancy = o_occupancy + OCC_W'(w_valid[k]);
    end

`ifdef PIPE_STAGE_PERF_EN
    slot_op_e              w_last_op;
    logic [PIPE_CNT_W-1:0] r_bubble_cnt;
    logic [PIPE_CNT_W-1:0] r_hold_cnt;

    assign w_last_op    = slot_op(i_flush, i_stall[STALL_LO+DEPTH-1], i_stall[STALL_LO+DEPTH]);
    assign o_bubble_cnt = r_bubble_cnt;
    assign o_hold_cnt   = r_hold_cnt;

    // Counters saturate rather than wrap; flush leaves them alone
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bubble_cnt <= '0;
            r_hold_cnt   <= '0;
        end else begin
            if (w_last_op == SLOT_BUBBLE && r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + PIPE_CNT_W'(1);
            if (w_last_op == SLOT_HOLD && o_valid && r_hold_cnt != '1) r_hold_cnt <= r_hold_cnt + PIPE_CNT_W'(1);
        end
    end
`else
    assign o_bubble_cnt = '0;
    assign o_hold_cnt   = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain: four chain configurations on a shared stimulus, checked against a slot-table model
module tb_pipe_stage_chain;

`ifdef PIPE_STAGE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, in_v;
    logic [7:0]  stall;
    logic [15:0] in_d;

    logic        ov [4];
    logic [15:0] od [4];
    logic [31:0] bc [4];
    logic [31:0] hc [4];
    logic [0:0]  occ0, occ1;
    logic [1:0]  occ2, occ3;

    int          dep [4] = '{1, 1, 2, 3};
    bit          clr [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic        mv  [4][4];
    logic [15:0] md  [4][4];
    logic [31:0] mb  [4];
    logic [31:0] mh  [4];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_stage_chain #(.WIDTH(16), .DEPTH(1), .STALL_LO(4), .CLEAR_DATA(1'b0)) u0 (
        .clk(clk), .rst(rst), .i_flush(flush), .i_stall(stall), .i_valid(in_v), .i_data(in_d),
        .o_valid(ov[0]), .o_data(od[0]), .o_occupancy(occ0), .o_bubble_cnt(bc[0]), .o_hold_cnt(hc[0]));
    pipe_stage_chain #(.WIDTH(16), .DEPTH(1), .STALL_LO(4), .CLEAR_DATA(1'b1)) u1 (
        .clk(clk), .rst(rst), .i_flush(flush), .i_stall(stall), .i_valid(in_v), .i_data(in_d),
        .o_valid(ov[1]), .o_data(od[1]), .o_occupancy(occ1), .o_bubble_cnt(bc[1]), .o_hold_cnt(hc[1]));
    pipe_stage_chain #(.WIDTH(16), .DEPTH(2), .STALL_LO(4), .CLEAR_DATA(1'b1)) u2 (
        .clk(clk), .rst(rst), .i_flush(flush), .i_stall(stall), .i_valid(in_v), .i_data(in_d),
        .o_valid(ov[2]), .o_data(od[2]), .o_occupancy(occ2), .o_bubble_cnt(bc[2]), .o_hold_cnt(hc[2]));
    pipe_stage_chain #(.WIDTH(16), .DEPTH(3), .STALL_LO(4), .CLEAR_DATA(1'b1)) u3 (
        .clk(clk), .rst(rst), .i_flush(flush), .i_stall(stall), .i_valid(in_v), .i_data(in_d),
        .o_valid(ov[3]), .o_data(od[3]), .o_occupancy(occ3), .o_bubble_cnt(bc[3]), .o_hold_cnt(hc[3]));

    function automatic int occ_of(input int i);
        case (i)
            0:       return int'(occ0);
            1:       return int'(occ1);
            2:       return int'(occ2);
            default: return int'(occ3);
        endcase
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] x);
        return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
    endfunction

    // Apply the slot rule table to every model slot using the inputs present at this edge
    task automatic model_step();
        logic        nv [4];
        logic [15:0] nd [4];
        int          last;
        logic        h, d;
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                for (int k = 0; k < 4; k++) begin
                    mv[i][k] = 1'b0;
                    md[i][k] = 16'h0;
                end
                mb[i] = 32'h0;
                mh[i] = 32'h0;
            end else begin
                last = dep[i] - 1;
                h = stall[4+last];
                d = stall[5+last];
                if (!flush && h && !d) mb[i] = sat_inc(mb[i]);
                if (!flush && h && d && mv[i][last]) mh[i] = sat_inc(mh[i]);
                for (int k = 0; k < dep[i]; k++) begin
                    h = stall[4+k];
                    d = stall[5+k];
                    nv[k] = mv[i][k];
                    nd[k] = md[i][k];
                    if (flush || (h && !d)) begin
                        nv[k] = 1'b0;
                        if (clr[i]) nd[k] = 16'h0;
                    end else if (!h) begin
                        if (k == 0) begin
                            nv[k] = in_v;
                            nd[k] = in_d;
                        end else begin
                            nv[k] = mv[i][k-1];
                            nd[k] = md[i][k-1];
                        end
                    end
                end
                for (int k = 0; k < dep[i]; k++) begin
                    mv[i][k] = nv[k];
                    md[i][k] = nd[k];
                end
            end
        end
    endtask

    task automatic cycle(input logic r, input logic f, input logic [7:0] s, input logic v, input logic [15:0] dt);
        rst   = r;
        flush = f;
        stall = s;
        in_v  = v;
        in_d  = dt;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, 8'($urandom), 1'b1, 16'($urandom));
        for (int i = 0; i < 4; i++) begin
            n_assert += 5;
            if (ov[i] !== 1'b0) begin n_fail++; $display("FAIL reset_valid[%0d]: got %b expected 0", i, ov[i]); end
            if (od[i] !== 16'h0) begin n_fail++; $display("FAIL reset_data[%0d]: got %h expected 0", i, od[i]); end
            if (occ_of(i) !== 0) begin n_fail++; $display("FAIL reset_occ[%0d]: got %0d expected 0", i, occ_of(i)); end
            if (bc[i] !== 32'h0) begin n_fail++; $display("FAIL reset_bubble[%0d]: got %h expected 0", i, bc[i]); end
            if (hc[i] !== 32'h0) begin n_fail++; $display("FAIL reset_hold[%0d]: got %h expected 0", i, hc[i]); end
        end
    endtask

    task automatic test_latency();
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 16'h0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 16'h00A5);
        n_assert += 4;
        if (ov[2] !== 1'b0) begin n_fail++; $display("FAIL lat_d2_e1_valid: got %b expected 0", ov[2]); end
        if (occ2 !== 2'd1) begin n_fail++; $display("FAIL lat_d2_e1_occ: got %0d expected 1", occ2); end
        if (ov[1] !== 1'b1) begin n_fail++; $display("FAIL lat_d1_valid: got %b expected 1", ov[1]); end
        if (od[1] !== 16'h00A5) begin n_fail++; $display("FAIL lat_d1_data: got %h expected 00a5", od[1]); end
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 16'h0);
        n_assert += 3;
        if (ov[2] !== 1'b1) begin n_fail++; $display("FAIL lat_d2_e2_valid: got %b expected 1", ov[2]); end
        if (od[2] !== 16'h00A5) begin n_fail++; $display("FAIL lat_d2_e2_data: got %h expected 00a5", od[2]); end
        if (occ2 !== 2'd1) begin n_fail++; $display("FAIL lat_d2_e2_occ: got %0d expected 1", occ2); end
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 16'h0);
        n_assert += 4;
        if (ov[2] !== 1'b0) begin n_fail++; $display("FAIL lat_d2_e3_valid: got %b expected 0", ov[2]); end
        if (occ2 !== 2'd0) begin n_fail++; $display("FAIL lat_d2_e3_occ: got %0d expected 0", occ2); end
        if (ov[3] !== 1'b1) begin n_fail++; $display("FAIL lat_d3_valid: got %b expected 1", ov[3]); end
        if (od[3] !== 16'h00A5) begin n_fail++; $display("FAIL lat_d3_data: got %h expected 00a5", od[3]); end
    endtask

    task automatic test_bubble();
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 16'h0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 16'h1234);
        cycle(1'b0, 1'b0, 8'h1F, 1'b1, 16'h1234);
        n_assert += 3;
        if (ov[1] !== 1'b0) begin n_fail++; $display("FAIL bubble_valid: got %b expected 0", ov[1]); end
        if (od[1] !== 16'h0) begin n_fail++; $display("FAIL bubble_data: got %h expected 0", od[1]); end
        if (bc[1] !== (PERF ? 32'd1 : 32'd0)) begin n_fail++; $display("FAIL bubble_cnt: got %0d expected %0d", bc[1], PERF); end
    endtask

    task automatic test_hold();
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 16'h0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 16'h0055);
        for (int n = 0; n < 3; n++) begin
            cycle(1'b0, 1'b0, 8'hFF, 1'b1, 16'($urandom));
            n_assert += 2;
            if (ov[1] !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d]: got %b expected 1", n, ov[1]); end
            if (od[1] !== 16'h0055) begin n_fail++; $display("FAIL hold_data[%0d]: got %h expected 0055", n, od[1]); end
        end
        n_assert++;
        if (hc[1] !== (PERF ? 32'd3 : 32'd0)) begin n_fail++; $display("FAIL hold_cnt: got %0d expected %0d", hc[1], PERF ? 3 : 0); end
    endtask

    task automatic test_flush();
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 16'h0);
        for (int n = 0; n < 3; n++) cycle(1'b0, 1'b0, 8'h00, 1'b1, 16'($urandom));
        n_assert++;
        if (occ3 !== 2'd3) begin n_fail++; $display("FAIL flush_fill_occ: got %0d expected 3", occ3); end
        cycle(1'b0, 1'b0, 8'hFF, 1'b1, 16'($urandom));
        cycle(1'b0, 1'b1, 8'hFF, 1'b1, 16'($urandom));
        n_assert += 5;
        if (occ3 !== 2'd0) begin n_fail++; $display("FAIL flush_occ: got %0d expected 0", occ3); end
        if (ov[3] !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", ov[3]); end
        if (occ2 !== 2'd0) begin n_fail++; $display("FAIL flush_occ_d2: got %0d expected 0", occ2); end
        if (hc[3] !== (PERF ? 32'd1 : 32'd0)) begin n_fail++; $display("FAIL flush_hold_cnt: got %0d expected %0d", hc[3], PERF); end
        if (bc[3] !== 32'd0) begin n_fail++; $display("FAIL flush_bubble_cnt: got %0d expected 0", bc[3]); end
    endtask

    task automatic test_clear_data();
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 16'h0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 16'h0077);
        n_assert += 2;
        if (ov[0] !== 1'b1) begin n_fail++; $display("FAIL keep_load_valid: got %b expected 1", ov[0]); end
        if (od[0] !== 16'h0077) begin n_fail++; $display("FAIL keep_load_data: got %h expected 0077", od[0]); end
        cycle(1'b0, 1'b0, 8'h1F, 1'b1, 16'($urandom));
        n_assert += 3;
        if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL keep_bubble_valid: got %b expected 0", ov[0]); end
        if (od[0] !== 16'h0077) begin n_fail++; $display("FAIL keep_bubble_data: got %h expected 0077", od[0]); end
        if (od[1] !== 16'h0) begin n_fail++; $display("FAIL clear_bubble_data: got %h expected 0", od[1]); end
        cycle(1'b1, 1'b0, 8'h1F, 1'b1, 16'($urandom));
        n_assert++;
        if (od[0] !== 16'h0) begin n_fail++; $display("FAIL keep_reset_data: got %h expected 0", od[0]); end
    endtask

    task automatic test_random();
        logic [8:0] m;
        logic [7:0] s;
        int         n_occ;
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 16'h0);
        for (int c = 0; c < 600; c++) begin
            m = (9'd1 << $urandom_range(0, 8)) - 9'd1;
            s = ($urandom_range(0, 7) == 0) ? 8'($urandom) : m[7:0];
            cycle($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0, s, 1'($urandom), 16'($urandom));
            for (int i = 0; i < 4; i++) begin
                n_occ = 0;
                for (int k = 0; k < dep[i]; k++) n_occ += int'(mv[i][k]);
                n_assert += 4;
                if (ov[i] !== mv[i][dep[i]-1]) begin n_fail++; $display("FAIL rnd_valid[%0d] c%0d: got %b expected %b", i, c, ov[i], mv[i][dep[i]-1]); end
                if (occ_of(i) !== n_occ) begin n_fail++; $display("FAIL rnd_occ[%0d] c%0d: got %0d expected %0d", i, c, occ_of(i), n_occ); end
                if (bc[i] !== (PERF ? mb[i] : 32'h0)) begin n_fail++; $display("FAIL rnd_bubble[%0d] c%0d: got %0d expected %0d", i, c, bc[i], PERF ? mb[i] : 32'h0); end
                if (hc[i] !== (PERF ? mh[i] : 32'h0)) begin n_fail++; $display("FAIL rnd_hold[%0d] c%0d: got %0d expected %0d", i, c, hc[i], PERF ? mh[i] : 32'h0); end
                if (clr[i] || mv[i][dep[i]-1]) begin
                    n_assert++;
                    if (od[i] !== md[i][dep[i]-1]) begin n_fail++; $display("FAIL rnd_data[%0d] c%0d: got %h expected %h", i, c, od[i], md[i][dep[i]-1]); end
                end
            end
        end
    endtask

    task automatic test_saturate();
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 16'h0);
`ifdef PIPE_STAGE_PERF_EN
        force u1.r_bubble_cnt = 32'hFFFF_FFFE;
        #1;
        release u1.r_bubble_cnt;
        mb[1] = 32'hFFFF_FFFE;
`endif
        for (int n = 0; n < 3; n++) begin
            cycle(1'b0, 1'b0, 8'h1F, 1'b0, 16'h0);
            n_assert++;
            if (bc[1] !== (PERF ? 32'hFFFF_FFFF : 32'h0)) begin n_fail++; $display("FAIL sat_bubble[%0d]: got %h expected %h", n, bc[1], PERF ? 32'hFFFF_FFFF : 32'h0); end
        end
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        stall = 8'h00;
        in_v  = 1'b0;
        in_d  = 16'h0;
        test_reset();
        test_latency();
        test_bubble();
        test_hold();
        test_flush();
        test_clear_data();
        test_random();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
